// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory-stall timeout and sticky trap.
// Optional CTRL_PERF_EN adds cycle and retired-instruction counters.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_op_code,
    input  logic       i_mem_ready,
    output logic       o_reg_dst,
    output logic       o_alu_src,
    output logic       o_mem_to_reg,
    output logic       o_reg_write,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_branch,
    output logic       o_jump,
    output logic       o_jal,
    output logic [1:0] o_alu_op,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_halted,
    output logic [1:0] o_trap_code,
    output logic [2:0] o_state
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0] o_cycle_cnt,
    output logic [31:0] o_instr_cnt
`endif
);

    // state    | meaning
    // IDLE     | post-reset, one cycle
    // FETCH    | load instruction register
    // DECODE   | latch opcode, check legality
    // EXEC     | ALU op / branch / jump
    // MEM      | wait for data memory, bounded by MEM_TIMEOUT
    // WB       | register write-back, advance PC
    // HALT     | sticky trap, left only by reset
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     r_state, w_state_nxt;
    logic [5:0] r_op_q;
    logic [7:0] r_wait_cnt, w_wait_nxt;
    logic [1:0] r_trap_code, w_trap_nxt;

    logic w_legal;
    logic w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_addi, w_is_j, w_is_jal;

    assign w_legal = (i_op_code == OP_R)   || (i_op_code == OP_LW)  || (i_op_code == OP_SW) ||
                     (i_op_code == OP_BEQ) || (i_op_code == OP_ADDI) ||
                     (i_op_code == OP_J)   || (i_op_code == OP_JAL);

    assign w_is_r    = (r_op_q == OP_R);
    assign w_is_lw   = (r_op_q == OP_LW);
    assign w_is_sw   = (r_op_q == OP_SW);
    assign w_is_beq  = (r_op_q == OP_BEQ);
    assign w_is_addi = (r_op_q == OP_ADDI);
    assign w_is_j    = (r_op_q == OP_J);
    assign w_is_jal  = (r_op_q == OP_JAL);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_op_q      <= '0;
            r_wait_cnt  <= '0;
            r_trap_code <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_trap_code <= w_trap_nxt;
            if (r_state == S_DECODE)
                r_op_q <= i_op_code;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_trap_nxt   = r_trap_code;
        w_wait_nxt   = '0;
        o_reg_dst    = 1'b0;
        o_alu_src    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_reg_write  = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_branch     = 1'b0;
        o_jump       = 1'b0;
        o_jal        = 1'b0;
        o_alu_op     = 2'b00;
        o_pc_write   = 1'b0;
        o_ir_write   = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                o_ir_write  = 1'b1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_HALT;
                    w_trap_nxt  = 2'b01;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_FETCH;
                if (w_is_r) begin
                    o_reg_dst   = 1'b1;
                    o_alu_op    = 2'b10;
                    w_state_nxt = S_WB;
                end
                if (w_is_addi) begin
                    o_alu_src   = 1'b1;
                    w_state_nxt = S_WB;
                end
                if (w_is_lw || w_is_sw) begin
                    o_alu_src   = 1'b1;
                    w_state_nxt = S_MEM;
                end
                if (w_is_beq) begin
                    o_alu_op   = 2'b01;
                    o_branch   = 1'b1;
                    o_pc_write = 1'b1;
                end
                if (w_is_j || w_is_jal) begin
                    o_jump     = 1'b1;
                    o_pc_write = 1'b1;
                end
                if (w_is_jal) begin
                    o_jal       = 1'b1;
                    o_reg_write = 1'b1;
                end
            end
            S_MEM: begin
                o_alu_src   = 1'b1;
                o_mem_read  = w_is_lw;
                o_mem_write = w_is_sw;
                // a ready on the timeout cycle still completes the access
                if (i_mem_ready) begin
                    if (w_is_lw) begin
                        w_state_nxt = S_WB;
                    end else begin
                        o_pc_write  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end else if (r_wait_cnt == TIMEOUT) begin
                    w_state_nxt = S_HALT;
                    w_trap_nxt  = 2'b10;
                end else begin
                    w_wait_nxt = r_wait_cnt + 8'd1;
                end
            end
            S_WB: begin
                o_reg_write  = 1'b1;
                o_pc_write   = 1'b1;
                o_mem_to_reg = w_is_lw;
                o_reg_dst    = w_is_r;
                w_state_nxt  = S_FETCH;
            end
            S_HALT: w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_halted    = (r_state == S_HALT);
    assign o_trap_code = r_trap_code;
    assign o_state     = r_state;

`ifdef CTRL_PERF_EN
    logic [31:0] r_cycle_cnt, r_instr_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (r_state != S_IDLE && r_state != S_HALT)
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (o_pc_write)
                r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
    assign o_instr_cnt = r_instr_cnt;
`endif

endmodule
